// File: rtl/vga_capture_monitor.sv
// VGA receive-side timing monitor: recovers sync timing and pixel coordinates, declares lock, and samples the quad centres.
// Optional active-pixel checksum on frame_sum is enabled by defining VGA_CAPTURE_CHECKSUM_EN.
module vga_capture_monitor #(
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int H_ACTIVE        = 640,
    parameter int H_TOTAL         = 800,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int V_ACTIVE        = 480,
    parameter int V_TOTAL         = 525,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk25MHz,
    input  logic        rst,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    input  logic        hsync,
    input  logic        vsync,
    output logic        locked,
    output logic        err_sticky,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic [7:0]  pix_rgb,
    output logic        frame_done,
    output logic [7:0]  quad_a,
    output logic [7:0]  quad_b,
    output logic [7:0]  quad_c,
    output logic [7:0]  quad_d,
    output logic [15:0] frame_sum
);

    localparam logic        L_SYNC_INV = 1'(SYNC_ACTIVE_LOW != 0);
    localparam logic [10:0] L_HT_M1    = 11'(H_TOTAL - 1);
    localparam logic [10:0] L_H_START  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] L_H_END    = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  L_VT_M1    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  L_V_START  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  L_V_END    = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0]  L_QX0      = 10'(H_ACTIVE / 4);
    localparam logic [9:0]  L_QX1      = 10'((3 * H_ACTIVE) / 4);
    localparam logic [9:0]  L_QY0      = 10'(V_ACTIVE / 4);
    localparam logic [9:0]  L_QY1      = 10'((3 * V_ACTIVE) / 4);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    logic [7:0]  r_rgb1;
    logic        r_hs1, r_hs2, r_vs1, r_vs2;
    logic [10:0] r_hcnt;
    logic [9:0]  r_vcnt;
    logic        r_vpend;
    state_t      r_state;
    logic        r_meas_ok;
    logic        r_locked, r_err, r_fd;
    logic        r_pix_valid;
    logic [9:0]  r_pix_x, r_pix_y;
    logic [7:0]  r_pix_rgb;
    logic [7:0]  r_sh_a, r_sh_b, r_sh_c, r_sh_d;
    logic [7:0]  r_quad_a, r_quad_b, r_quad_c, r_quad_d;

    logic        w_hs_lead, w_vs_lead, w_zero;
    logic        w_line_good, w_line_bad, w_frame_good;
    logic [10:0] w_hcnt_nxt;
    logic [9:0]  w_vcnt_nxt;
    logic        w_vpend_nxt;
    state_t      w_state_nxt;
    logic        w_meas_ok_nxt;
    logic        w_fd, w_lost;
    logic        w_h_act, w_v_act, w_pv_nxt;

    // Input capture; syncs are stored normalised so that 1 means "pulse active".
    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            r_rgb1 <= 8'd0;
            r_hs1  <= 1'b0;
            r_hs2  <= 1'b0;
            r_vs1  <= 1'b0;
            r_vs2  <= 1'b0;
        end else begin
            r_rgb1 <= {red, green, blue};
            r_hs1  <= hsync ^ L_SYNC_INV;
            r_hs2  <= r_hs1;
            r_vs1  <= vsync ^ L_SYNC_INV;
            r_vs2  <= r_vs1;
        end
    end

    assign w_hs_lead    = r_hs1 & ~r_hs2;
    assign w_vs_lead    = r_vs1 & ~r_vs2;
    assign w_zero       = w_hs_lead & (r_vpend | w_vs_lead);
    assign w_line_good  = (r_hcnt == L_HT_M1);
    assign w_line_bad   = w_hs_lead & ~w_line_good;
    assign w_frame_good = (r_vcnt == L_VT_M1);

    // Counter next-state; a pending vsync edge is consumed by the next hsync edge.
    always_comb begin
        w_hcnt_nxt  = r_hcnt;
        w_vcnt_nxt  = r_vcnt;
        w_vpend_nxt = r_vpend;
        if (w_hs_lead) begin
            w_hcnt_nxt = 11'd0;
        end else if (r_hcnt != 11'h7FF) begin
            w_hcnt_nxt = r_hcnt + 11'd1;
        end else begin
            w_hcnt_nxt = r_hcnt;
        end
        if (w_zero) begin
            w_vcnt_nxt  = 10'd0;
            w_vpend_nxt = 1'b0;
        end else if (w_hs_lead) begin
            w_vcnt_nxt  = (r_vcnt != 10'h3FF) ? (r_vcnt + 10'd1) : r_vcnt;
            w_vpend_nxt = r_vpend | w_vs_lead;
        end else begin
            w_vcnt_nxt  = r_vcnt;
            w_vpend_nxt = r_vpend | w_vs_lead;
        end
    end

    // Lock FSM next-state; MEASURE remembers whether every line of the trial frame was good.
    always_comb begin
        w_state_nxt   = r_state;
        w_meas_ok_nxt = r_meas_ok;
        w_fd          = 1'b0;
        w_lost        = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_zero) begin
                    w_state_nxt   = MEASURE;
                    w_meas_ok_nxt = 1'b1;
                end else begin
                    w_state_nxt   = SEARCH;
                end
            end
            MEASURE: begin
                if (w_zero) begin
                    if (r_meas_ok && w_line_good && w_frame_good) begin
                        w_state_nxt = LOCKED;
                        w_fd        = 1'b1;
                    end else begin
                        w_state_nxt = SEARCH;
                    end
                end else if (w_line_bad) begin
                    w_meas_ok_nxt = 1'b0;
                end else begin
                    w_meas_ok_nxt = r_meas_ok;
                end
            end
            LOCKED: begin
                if (w_line_bad || (w_zero && !w_frame_good)) begin
                    w_state_nxt = SEARCH;
                    w_lost      = 1'b1;
                end else if (w_zero) begin
                    w_fd        = 1'b1;
                end else begin
                    w_state_nxt = LOCKED;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    assign w_h_act  = (w_hcnt_nxt >= L_H_START) && (w_hcnt_nxt < L_H_END);
    assign w_v_act  = (w_vcnt_nxt >= L_V_START) && (w_vcnt_nxt < L_V_END);
    assign w_pv_nxt = w_h_act && w_v_act && (w_state_nxt == LOCKED);

    // Timing state and status registers.
    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            r_hcnt    <= 11'd0;
            r_vcnt    <= 10'd0;
            r_vpend   <= 1'b0;
            r_state   <= SEARCH;
            r_meas_ok <= 1'b0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_fd      <= 1'b0;
        end else begin
            r_hcnt    <= w_hcnt_nxt;
            r_vcnt    <= w_vcnt_nxt;
            r_vpend   <= w_vpend_nxt;
            r_state   <= w_state_nxt;
            r_meas_ok <= w_meas_ok_nxt;
            r_locked  <= (w_state_nxt == LOCKED);
            r_err     <= r_err | w_lost;
            r_fd      <= w_fd;
        end
    end

    // Pixel outputs; coordinates and colour hold outside the active region.
    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            r_pix_valid <= 1'b0;
            r_pix_x     <= 10'd0;
            r_pix_y     <= 10'd0;
            r_pix_rgb   <= 8'd0;
        end else begin
            r_pix_valid <= w_pv_nxt;
            if (w_pv_nxt) begin
                r_pix_x   <= 10'(w_hcnt_nxt - L_H_START);
                r_pix_y   <= w_vcnt_nxt - L_V_START;
                r_pix_rgb <= r_rgb1;
            end
        end
    end

    // Quad shadows fill during the frame and are published together at frame_done.
    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            r_sh_a   <= 8'd0;
            r_sh_b   <= 8'd0;
            r_sh_c   <= 8'd0;
            r_sh_d   <= 8'd0;
            r_quad_a <= 8'd0;
            r_quad_b <= 8'd0;
            r_quad_c <= 8'd0;
            r_quad_d <= 8'd0;
        end else begin
            if (w_lost) begin
                r_sh_a <= 8'd0;
                r_sh_b <= 8'd0;
                r_sh_c <= 8'd0;
                r_sh_d <= 8'd0;
            end else if (r_pix_valid) begin
                if (r_pix_x == L_QX0 && r_pix_y == L_QY0) r_sh_a <= r_pix_rgb;
                if (r_pix_x == L_QX1 && r_pix_y == L_QY0) r_sh_b <= r_pix_rgb;
                if (r_pix_x == L_QX0 && r_pix_y == L_QY1) r_sh_c <= r_pix_rgb;
                if (r_pix_x == L_QX1 && r_pix_y == L_QY1) r_sh_d <= r_pix_rgb;
            end
            if (w_fd) begin
                r_quad_a <= r_sh_a;
                r_quad_b <= r_sh_b;
                r_quad_c <= r_sh_c;
                r_quad_d <= r_sh_d;
            end
        end
    end

`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [15:0] r_acc;
    logic [15:0] r_frame_sum;

    // Active-pixel checksum; discarded on loss of lock so a relock starts clean.
    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            r_acc       <= 16'd0;
            r_frame_sum <= 16'd0;
        end else if (w_fd) begin
            r_frame_sum <= r_acc;
            r_acc       <= 16'd0;
        end else if (w_lost) begin
            r_acc       <= 16'd0;
        end else if (r_pix_valid) begin
            r_acc       <= r_acc + {8'd0, r_pix_rgb};
        end
    end

    assign frame_sum = r_frame_sum;
`else
    assign frame_sum = 16'd0;
`endif

    assign locked     = r_locked;
    assign err_sticky = r_err;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_valid  = r_pix_valid;
    assign pix_rgb    = r_pix_rgb;
    assign frame_done = r_fd;
    assign quad_a     = r_quad_a;
    assign quad_b     = r_quad_b;
    assign quad_c     = r_quad_c;
    assign quad_d     = r_quad_d;

endmodule

// File: tb/tb_vga_capture_monitor.sv
// Self-checking bench for vga_capture_monitor using a reduced raster so whole frames stay short.
`timescale 1ns/1ps
module tb_vga_capture_monitor;

    localparam int HS = 4, HB = 4, HA = 32, HT = 48;
    localparam int VS = 2, VB = 3, VA = 16, VT = 24;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;

    logic        clk25MHz = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        hsync, vsync;
    logic        locked, err_sticky, pix_valid, frame_done;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  pix_rgb, quad_a, quad_b, quad_c, quad_d;
    logic [15:0] frame_sum;

    vga_capture_monitor #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk25MHz(clk25MHz), .rst(rst),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync),
        .locked(locked), .err_sticky(err_sticky),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .frame_done(frame_done),
        .quad_a(quad_a), .quad_b(quad_b), .quad_c(quad_c), .quad_d(quad_d),
        .frame_sum(frame_sum)
    );

    always #20 clk25MHz = ~clk25MHz;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] tl, tr, bl, br;
        logic [7:0] qa, qb, qc, qd;
    } vec_t;
    vec_t vecs[4];

    // Video source state
    int         gen_frame_cnt = 0;
    int         gen_v = 0;
    int         gen_h = 0;
    int         gen_short_v = -1;
    logic       gen_vs_early = 1'b0;
    logic [7:0] gen_rgb = 8'h00;
    logic [7:0] pat_tl = 8'h24, pat_tr = 8'h24, pat_bl = 8'h24, pat_br = 8'h24;
    logic [7:0] cur_tl, cur_tr, cur_bl, cur_br;

    initial begin : gen
        hsync = 1'b1;
        vsync = 1'b1;
        {red, green, blue} = 8'h00;
        forever begin
            gen_frame_cnt = gen_frame_cnt + 1;
            cur_tl = pat_tl; cur_tr = pat_tr; cur_bl = pat_bl; cur_br = pat_br;
            for (int v = 0; v < VT; v++) begin
                int len;
                len = HT;
                if (v == gen_short_v) begin
                    len = HT - 1;
                    gen_short_v = -1;
                end
                for (int h = 0; h < len; h++) begin
                    gen_v = v;
                    gen_h = h;
                    hsync = (h < HS) ? 1'b0 : 1'b1;
                    vsync = ((v < VS) || (gen_vs_early && v == VT - 1 && h >= HT - 16)) ? 1'b0 : 1'b1;
                    if (h >= HST && h < HST + HA && v >= VST && v < VST + VA) begin
                        if (v - VST < VA / 2) gen_rgb = (h - HST < HA / 2) ? cur_tl : cur_tr;
                        else                  gen_rgb = (h - HST < HA / 2) ? cur_bl : cur_br;
                    end else begin
                        gen_rgb = 8'h5A;
                    end
                    {red, green, blue} = gen_rgb;
                    @(posedge clk25MHz);
                    #1;
                end
            end
        end
    end

    // Two-stage delay of what was driven, aligned with the DUT pixel outputs
    int         d1_h = 0, d1_v = 0, d2_h = 0, d2_v = 0;
    logic [7:0] d1_rgb = 8'h00, d2_rgb = 8'h00;
    always @(posedge clk25MHz) begin
        d1_h <= gen_h; d1_v <= gen_v; d1_rgb <= gen_rgb;
        d2_h <= d1_h;  d2_v <= d1_v;  d2_rgb <= d1_rgb;
    end

    int   mon_pix_cnt = 0, mon_bad = 0, mon_last_pix = 0, mon_last_bad = 0;
    int   mon_rise_cnt = 0, mon_rise_bad = 0, mon_fall_cnt = 0, mon_fall_v = -1, mon_fall_h = -1;
    logic mon_prev_locked = 1'b0;

    always @(negedge clk25MHz) begin
        if (pix_valid) begin
            mon_pix_cnt <= mon_pix_cnt + 1;
            if (!(d2_h >= HST && d2_h < HST + HA && d2_v >= VST && d2_v < VST + VA &&
                  int'(pix_x) == d2_h - HST && int'(pix_y) == d2_v - VST && pix_rgb == d2_rgb))
                mon_bad <= mon_bad + 1;
        end
        if (frame_done) begin
            mon_last_pix <= mon_pix_cnt;
            mon_last_bad <= mon_bad;
            mon_pix_cnt  <= 0;
            mon_bad      <= 0;
        end
        if (locked && !mon_prev_locked) begin
            mon_rise_cnt <= mon_rise_cnt + 1;
            if (!(frame_done && d2_v == 0 && d2_h == 0)) mon_rise_bad <= mon_rise_bad + 1;
        end
        if (!locked && mon_prev_locked) begin
            mon_fall_cnt <= mon_fall_cnt + 1;
            mon_fall_v   <= d2_v;
            mon_fall_h   <= d2_h;
        end
        mon_prev_locked <= locked;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_gen(input int f, input int line);
        while (gen_frame_cnt < f || (gen_frame_cnt == f && gen_v < line)) @(posedge clk25MHz);
        @(negedge clk25MHz);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_status"}, {29'd0, locked, err_sticky, frame_done}, 32'd0);
        check({name, "_pix"}, {3'd0, pix_valid, pix_x, pix_y, pix_rgb}, 32'd0);
        check({name, "_quads"}, {quad_a, quad_b, quad_c, quad_d}, 32'd0);
        check({name, "_sum"}, {16'd0, frame_sum}, 32'd0);
    endtask

    initial begin : watchdog
        #(60000 * 40);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        logic [31:0] prev_q;
        logic [31:0] exp_q;
        logic [31:0] exp_sum;
        vecs[0] = '{8'hE0, 8'h1C, 8'hE0, 8'h1C, 8'hE0, 8'h1C, 8'hE0, 8'h1C};
        vecs[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[2] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        vecs[3] = '{8'hFF, 8'h00, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h01};

        // Reset held while frame 1 starts; released a few lines in
        rst = 1'b1;
        wait_gen(1, 1);
        check_all_zero("reset");
        wait_gen(1, 3);
        rst = 1'b0;

        wait_gen(2, 3);
        check("measure_unlocked", 32'(locked), 32'd0);
        wait_gen(3, 3);
        check("lock_after_frame2", 32'(locked), 32'd1);
        check("lock_rise_count", 32'(mon_rise_cnt), 32'd1);
        check("lock_rise_with_fd", 32'(mon_rise_bad), 32'd0);
        check("err_clear", 32'(err_sticky), 32'd0);
        wait_gen(3, 22);
        check("hold_pix_x", 32'(pix_x), 32'(HA - 1));
        check("hold_pix_y", 32'(pix_y), 32'(VA - 1));
        wait_gen(4, 3);
        check("pix_count", 32'(mon_last_pix), 32'(HA * VA));
        check("pix_coords", 32'(mon_last_bad), 32'd0);
        check("quad_first", {quad_a, quad_b, quad_c, quad_d}, 32'h24242424);
        prev_q = 32'h24242424;

        for (int i = 0; i < 4; i++) begin
            wait_gen(4 + 2 * i, 3);
            pat_tl = vecs[i].tl; pat_tr = vecs[i].tr; pat_bl = vecs[i].bl; pat_br = vecs[i].br;
            wait_gen(5 + 2 * i, 10);
            check("quad_hold_midframe", {quad_a, quad_b, quad_c, quad_d}, prev_q);
            wait_gen(6 + 2 * i, 3);
            exp_q = {vecs[i].qa, vecs[i].qb, vecs[i].qc, vecs[i].qd};
`ifdef VGA_CAPTURE_CHECKSUM_EN
            exp_sum = 32'(16'(32'd128 * (32'(vecs[i].tl) + 32'(vecs[i].tr) + 32'(vecs[i].bl) + 32'(vecs[i].br))));
`else
            exp_sum = 32'd0;
`endif
            check("quad_vec", {quad_a, quad_b, quad_c, quad_d}, exp_q);
            check("frame_sum", {16'd0, frame_sum}, exp_sum);
            check("vec_pix_coords", 32'(mon_last_bad), 32'd0);
            prev_q = exp_q;
        end

        // One 47-clock line while locked
        gen_short_v = 10;
        wait_gen(12, 9);
        check("pre_short_locked", 32'(locked), 32'd1);
        check("pre_short_err", 32'(err_sticky), 32'd0);
        wait_gen(12, 13);
        check("short_unlocked", 32'(locked), 32'd0);
        check("short_err", 32'(err_sticky), 32'd1);
        check("short_fall_count", 32'(mon_fall_cnt), 32'd1);
        check("short_fall_line", 32'(mon_fall_v), 32'd11);
        check("short_fall_pos", 32'(mon_fall_h), 32'd0);
        wait_gen(15, 3);
        check("short_relock", 32'(locked), 32'd1);
        check("short_err_kept", 32'(err_sticky), 32'd1);

        // Vsync now leads hsync by 16 clocks; then a one-clock reset mid-frame
        gen_vs_early = 1'b1;
        wait_gen(16, 10);
        check("early_vs_locked", 32'(locked), 32'd1);
        check("early_vs_no_fall", 32'(mon_fall_cnt), 32'd1);
        rst = 1'b1;
        @(posedge clk25MHz);
        @(negedge clk25MHz);
        check_all_zero("midrst");
        rst = 1'b0;
        wait_gen(17, 3);
        check("midrst_unlocked", 32'(locked), 32'd0);
        wait_gen(19, 3);
        check("midrst_relock", 32'(locked), 32'd1);
        check("midrst_err", 32'(err_sticky), 32'd0);
        check("midrst_pix_count", 32'(mon_last_pix), 32'(HA * VA));
        check("midrst_pix_coords", 32'(mon_last_bad), 32'd0);
        check("midrst_rise_with_fd", 32'(mon_rise_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
